crc_sequencer: RTL and testbench
================================

Name: crc_sequencer

Overview:
Sequencing controller for the CRC datapath. It accepts a CRC configuration and a byte stream, and runs a bit-serial CRC update (one message bit per clock). It owns a single `reflect1N` instance and time-shares it between two uses: input-byte reflection (refin) and final-register reflection (refout). The final XOR-out is applied before the result is presented. It sits between the chip I/O byte interface and the result readout.

Parameters:
- MAX_BITS, 32, maximum CRC width and register width.
- MAX_BIT_COUNT, 5, width of width-minus-one fields; equals log2(MAX_BITS).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse. Latches all cfg_* inputs and loads crc = cfg_init & mask.
- cfg_width_m1  input  MAX_BIT_COUNT  CRC width minus 1 (CRC-8 = 7, CRC-32 = 31).
- cfg_poly  input  MAX_BITS  polynomial, normal form, implicit top bit omitted.
- cfg_init  input  MAX_BITS  initial register value.
- cfg_xorout  input  MAX_BITS  final XOR value.
- cfg_refin  input  1  reflect each input byte before processing.
- cfg_refout  input  1  reflect the final register before XOR-out.
- in_valid  input  1  input byte valid.
- in_data  input  8  input byte.
- in_last  input  1  marks the accepted byte as the final byte of the message.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- out_valid  output  1  result valid.
- out_crc  output  MAX_BITS  result, zero above the CRC width.
- out_ready  input  1  result consumed when out_valid && out_ready.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state = IDLE; crc register 0; config registers 0. Reset has priority over every other event in any state; an in-flight message is discarded with no partial output.
- mask = all-ones when width_m1 = MAX_BITS-1, otherwise (1 << (width_m1+1)) - 1.
- Reflector bitwidth input is width-minus-one: 7 reflects a byte; cfg_width_m1 reflects the CRC register. Inputs are zero-extended to MAX_BITS.
- States:
  - IDLE: start → FETCH. Other inputs are ignored.
  - FETCH: in_ready = 1. On handshake, latch sh = refin ? reflect(in_data, 7) : in_data, latch the last flag, clear bit_cnt → SHIFT.
  - SHIFT: exactly 8 cycles, one bit per cycle, MSB of sh first:
    - top = crc[width_m1] ^ sh[7]
    - crc = ((crc << 1) & mask) ^ (top ? cfg_poly & mask : 0)
    - sh <<= 1
    - After bit 7: last ? FINAL : FETCH.
  - FINAL: 1 cycle. res = (refout ? reflect(crc, width_m1) : crc) ^ xorout, masked → DONE.
  - DONE: out_valid = 1 and out_crc = res, both held stable until out_ready → IDLE (out_valid low the following cycle).
- Reflector input mux: FINAL selects the crc register; every other state selects in_data. One reflector instance only.
- Throughput: 9 cycles per byte when in_valid is continuously high. Latency from last-byte handshake to out_valid is 10 cycles.
- start is ignored while busy. Config is sampled only on start and never changes mid-message.
- Widths below 8 are legal: the serial update is width-agnostic.
- in_valid while not in FETCH is not accepted (in_ready = 0). The data is simply not consumed.
- Zero-length messages are not supported; every message contains at least one byte marked in_last.

Decomposition:
- Shared package `crc_pkg`:
  - state enum with values IDLE, FETCH, SHIFT, FINAL, DONE
  - BYTE_BITS = 8
  - REFLECT_BYTE_M1 = 7
- Sub-module: one instance of the existing `reflect1N`, fed through the mux above. Everything else is inline.

Test Plan:
- CRC-32 (width_m1 31, poly 04C11DB7, init FFFFFFFF, xorout FFFFFFFF, refin = refout = 1) over ASCII "123456789", in_valid held high → out_crc = CBF43926. First out_valid appears 10 cycles after the 9th handshake.
- CRC-16/CCITT-FALSE (width_m1 15, poly 1021, init FFFF, xorout 0, no reflection), same string → out_crc = 000029B1. Bits 31:16 must be zero.
- CRC-8 (width_m1 7, poly 07, init 0, xorout 0), same string → 000000F4. CRC-16/ARC (poly 8005, init 0, refin = refout = 1) → 0000BB3D.
- Backpressure: in_valid toggled pseudo-randomly and out_ready held low 20 cycles, CRC-32 string → out_crc stays CBF43926 and out_valid stays high for the whole hold. Release out_ready → IDLE the next cycle.
- start pulsed while busy with different config → ignored; result still CBF43926.
- reset asserted in SHIFT mid-message → next cycle busy = 0, in_ready = 0, out_valid = 0. A fresh CRC-32 run afterwards yields CBF43926.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC sequencer slice.
//   state_t         : sequencer FSM states
//   BYTE_BITS       : bits shifted per accepted input byte
//   REFLECT_BYTE_M1 : reflector width-minus-one that reverses a single byte
package crc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int BYTE_BITS       = 8;
    localparam int REFLECT_BYTE_M1 = 7;

endpackage

// File: rtl/reflect1N.sv
// Bit reflector: reverses bits [bitwidth_m1:0] of data and returns them
// zero-extended to MAX_BITS. Bits of data above bitwidth_m1 are discarded.
//   data        : word to reflect
//   bitwidth_m1 : number of bits to reflect, minus one
//   result      : reflected value, zero above bitwidth_m1
module reflect1N #(
    parameter int MAX_BITS      = 32,
    parameter int MAX_BIT_COUNT = 5
) (
    input  logic [MAX_BITS-1:0]      data,
    input  logic [MAX_BIT_COUNT-1:0] bitwidth_m1,
    output logic [MAX_BITS-1:0]      result
);

    logic [MAX_BITS-1:0]      reversed;
    logic [MAX_BIT_COUNT-1:0] shift_amt;

    // Reverse the full word, then slide the reflected field down to bit 0;
    // anything that was above bitwidth_m1 falls off the bottom.
    always_comb begin
        reversed = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            reversed[i] = data[MAX_BITS-1-i];
        end
        shift_amt = MAX_BIT_COUNT'(MAX_BITS - 1) - bitwidth_m1;
        result    = reversed >> shift_amt;
    end

endmodule

// File: rtl/crc_sequencer.sv
// Bit-serial CRC sequencer. Latches a CRC configuration on start, accepts a
// byte stream (one byte per 9 cycles at best), updates the CRC one bit per
// clock, then applies optional output reflection and XOR-out.
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse, latches cfg_* and loads init
//   cfg_*             : width-1, polynomial, init, xorout, refin, refout
//   in_valid/in_ready : byte handshake, in_data / in_last payload
//   out_valid/out_ready : result handshake, out_crc payload
//   busy              : high in every state except IDLE
//
// state | meaning
// IDLE  | waiting for start
// FETCH | in_ready high, waiting for an input byte
// SHIFT | eight serial update cycles, MSB of sh first
// FINAL | reflect (optional) and XOR-out the register
// DONE  | result presented until out_ready
module crc_sequencer
    import crc_pkg::*;
#(
    parameter int MAX_BITS      = 32,
    parameter int MAX_BIT_COUNT = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [MAX_BIT_COUNT-1:0] cfg_width_m1,
    input  logic [MAX_BITS-1:0]      cfg_poly,
    input  logic [MAX_BITS-1:0]      cfg_init,
    input  logic [MAX_BITS-1:0]      cfg_xorout,
    input  logic                     cfg_refin,
    input  logic                     cfg_refout,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [MAX_BITS-1:0]      out_crc,
    input  logic                     out_ready,
    output logic                     busy
);

    state_t                   state;
    logic [MAX_BIT_COUNT-1:0] width_m1;
    logic [MAX_BITS-1:0]      poly;
    logic [MAX_BITS-1:0]      xorout;
    logic                     refin;
    logic                     refout;
    logic [MAX_BITS-1:0]      crc;
    logic [BYTE_BITS-1:0]     sh;
    logic                     last;
    logic [2:0]               bit_cnt;

    logic [MAX_BITS-1:0]      mask;
    logic [MAX_BITS-1:0]      start_mask;
    logic                     top;
    logic [MAX_BITS-1:0]      crc_next;
    logic [MAX_BITS-1:0]      refl_data;
    logic [MAX_BIT_COUNT-1:0] refl_width_m1;
    logic [MAX_BITS-1:0]      refl_result;

    // One extra bit of headroom so width_m1 = MAX_BITS-1 yields all ones
    // without a special case.
    function automatic logic [MAX_BITS-1:0] mask_of(input logic [MAX_BIT_COUNT-1:0] w);
        logic [MAX_BITS:0] wide;
        wide = ((MAX_BITS+1)'(1) << ({1'b0, w} + (MAX_BIT_COUNT+1)'(1))) - (MAX_BITS+1)'(1);
        return wide[MAX_BITS-1:0];
    endfunction

    always_comb begin
        mask       = mask_of(width_m1);
        start_mask = mask_of(cfg_width_m1);
        top        = crc[width_m1] ^ sh[BYTE_BITS-1];
        crc_next   = ((crc << 1) & mask) ^ (top ? (poly & mask) : '0);
    end

    // The single reflector is shared: the CRC register in FINAL, the input
    // byte everywhere else.
    always_comb begin
        if (state == FINAL) begin
            refl_data     = crc;
            refl_width_m1 = width_m1;
        end else begin
            refl_data     = {{(MAX_BITS-BYTE_BITS){1'b0}}, in_data};
            refl_width_m1 = MAX_BIT_COUNT'(REFLECT_BYTE_M1);
        end
    end

    reflect1N #(
        .MAX_BITS      (MAX_BITS),
        .MAX_BIT_COUNT (MAX_BIT_COUNT)
    ) u_reflect (
        .data        (refl_data),
        .bitwidth_m1 (refl_width_m1),
        .result      (refl_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            width_m1  <= '0;
            poly      <= '0;
            xorout    <= '0;
            refin     <= 1'b0;
            refout    <= 1'b0;
            crc       <= '0;
            sh        <= '0;
            last      <= 1'b0;
            bit_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_crc   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        width_m1 <= cfg_width_m1;
                        poly     <= cfg_poly;
                        xorout   <= cfg_xorout;
                        refin    <= cfg_refin;
                        refout   <= cfg_refout;
                        crc      <= cfg_init & start_mask;
                        state    <= FETCH;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        sh       <= refin ? refl_result[BYTE_BITS-1:0] : in_data;
                        last     <= in_last;
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    crc     <= crc_next;
                    sh      <= sh << 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(BYTE_BITS - 1)) begin
                        if (last) begin
                            state <= FINAL;
                        end else begin
                            state    <= FETCH;
                            in_ready <= 1'b1;
                        end
                    end
                end
                FINAL: begin
                    out_crc   <= ((refout ? refl_result : crc) ^ xorout) & mask;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_sequencer.sv
module tb_crc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  cfg_width_m1;
    logic [31:0] cfg_poly;
    logic [31:0] cfg_init;
    logic [31:0] cfg_xorout;
    logic        cfg_refin;
    logic        cfg_refout;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_crc;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_passed = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    always #5 clk = ~clk;

    crc_sequencer #(.MAX_BITS(32), .MAX_BIT_COUNT(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_width_m1 (cfg_width_m1),
        .cfg_poly     (cfg_poly),
        .cfg_init     (cfg_init),
        .cfg_xorout   (cfg_xorout),
        .cfg_refin    (cfg_refin),
        .cfg_refout   (cfg_refout),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_crc      (out_crc),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic pulse_start(input logic [4:0] w, input logic [31:0] p, input logic [31:0] i,
                               input logic [31:0] x, input logic ri, input logic ro);
        @(negedge clk);
        cfg_width_m1 = w;
        cfg_poly     = p;
        cfg_init     = i;
        cfg_xorout   = x;
        cfg_refin    = ri;
        cfg_refout   = ro;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Feeds "123456789"; returns cycles from last handshake to out_valid
    // (0 on timeout). random_valid toggles in_valid; poke pulses start
    // with a different config mid-message.
    task automatic send_msg(input bit random_valid, input bit poke, output int latency);
        int idx = 0;
        int guard = 0;
        bit hs;
        latency = 0;
        while (idx < 9 && guard < 2000) begin
            @(negedge clk);
            guard++;
            in_valid = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = msg[idx];
            in_last  = (idx == 8);
            start    = poke && (idx == 4);
            if (poke && idx == 4) begin
                cfg_width_m1 = 5'd15;
                cfg_poly     = 32'h0000_1021;
                cfg_init     = 32'h0000_0000;
                cfg_refin    = 1'b0;
            end
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) idx++;
        end
        if (idx < 9) begin
            chk("feed_timeout", 32'(idx), 32'd9);
            return;
        end
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            start    = 1'b0;
            if (out_valid) begin
                latency = c;
                break;
            end
        end
        if (latency == 0) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        reset        = 1'b1;
        start        = 1'b0;
        cfg_width_m1 = '0;
        cfg_poly     = '0;
        cfg_init     = '0;
        cfg_xorout   = '0;
        cfg_refin    = 1'b0;
        cfg_refout   = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        out_ready    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_crc", out_crc, 32'd0);
        reset = 1'b0;

        // CRC-32
        pulse_start(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("crc32_busy", 32'(busy), 32'd1);
        send_msg(1'b0, 1'b0, lat);
        chk("crc32_latency", 32'(lat), 32'd10);
        chk("crc32_value", out_crc, 32'hCBF4_3926);
        @(negedge clk);
        chk("crc32_out_valid_drop", 32'(out_valid), 32'd0);

        // CRC-16/CCITT-FALSE
        pulse_start(5'd15, 32'h0000_1021, 32'h0000_FFFF, 32'h0, 1'b0, 1'b0);
        send_msg(1'b0, 1'b0, lat);
        chk("ccitt_value", out_crc, 32'h0000_29B1);
        chk("ccitt_upper_zero", {16'h0, out_crc[31:16]}, 32'd0);

        // CRC-8
        pulse_start(5'd7, 32'h0000_0007, 32'h0, 32'h0, 1'b0, 1'b0);
        send_msg(1'b0, 1'b0, lat);
        chk("crc8_value", out_crc, 32'h0000_00F4);
        chk("crc8_latency", 32'(lat), 32'd10);

        // CRC-16/ARC
        pulse_start(5'd15, 32'h0000_8005, 32'h0, 32'h0, 1'b1, 1'b1);
        send_msg(1'b0, 1'b0, lat);
        chk("arc_value", out_crc, 32'h0000_BB3D);

        // Backpressure on both sides
        @(negedge clk);
        out_ready = 1'b0;
        pulse_start(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        send_msg(1'b1, 1'b0, lat);
        for (int k = 0; k < 20; k++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_crc", out_crc, 32'hCBF4_3926);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);

        // start while busy is ignored
        pulse_start(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        send_msg(1'b0, 1'b1, lat);
        chk("poke_value", out_crc, 32'hCBF4_3926);
        chk("poke_latency", 32'(lat), 32'd10);
        @(negedge clk);
        chk("poke_idle_after", 32'(busy), 32'd0);

        // Reset mid-message while in SHIFT
        pulse_start(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h31;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        chk("mid_in_ready_before", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        pulse_start(5'd31, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        send_msg(1'b0, 1'b0, lat);
        chk("after_rst_value", out_crc, 32'hCBF4_3926);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
